// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and the datapath width.
package lsu_pkg;
    localparam int XLEN = 64;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_RD,
        WRITE,
        RESP
    } lsu_state_t;
endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: load extract with sign/zero extension,
// and sub-word store merge into the doubleword read back from memory.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [2:0]      offset,
    input  logic [XLEN-1:0] rdata,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data,
    output logic [XLEN-1:0] merge_data
);
    logic [5:0]      shamt;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] size_mask;
    logic [XLEN-1:0] lane_mask;

    assign shamt   = {offset, 3'b000};
    assign shifted = rdata >> shamt;

    always_comb begin
        load_data = shifted;
        case (funct3)
            F3_B:    load_data = {{56{shifted[7]}},  shifted[7:0]};
            F3_H:    load_data = {{48{shifted[15]}}, shifted[15:0]};
            F3_W:    load_data = {{32{shifted[31]}}, shifted[31:0]};
            F3_BU:   load_data = {56'd0, shifted[7:0]};
            F3_HU:   load_data = {48'd0, shifted[15:0]};
            F3_WU:   load_data = {32'd0, shifted[31:0]};
            default: load_data = shifted;
        endcase
    end

    // funct3[1:0] is log2 of the access size for both loads and stores
    always_comb begin
        size_mask = '1;
        case (funct3[1:0])
            2'd0:    size_mask = 64'h0000_0000_0000_00FF;
            2'd1:    size_mask = 64'h0000_0000_0000_FFFF;
            2'd2:    size_mask = 64'h0000_0000_FFFF_FFFF;
            default: size_mask = '1;
        endcase
    end

    assign lane_mask  = size_mask << shamt;
    assign merge_data = (rdata & ~lane_mask) | ((wdata << shamt) & lane_mask);
endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding RV64 load/store initiator for the doubleword data_memory
// port; sub-word stores are done as read-modify-write.
module load_store_unit #(
    parameter int ADDR_W = 8,
    parameter int XLEN   = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_error,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] endereco,
    output logic [XLEN-1:0]   write_data,
    input  logic [XLEN-1:0]   read_data
);
    import lsu_pkg::*;

    lsu_state_t      state, state_nxt;
    logic [2:0]      r_funct3;
    logic [2:0]      r_offset;
    logic [XLEN-1:0] r_wdata;
    logic            misaligned;
    logic            illegal;
    logic            req_err;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] merge_data;

    always_comb begin
        misaligned = 1'b0;
        case (req_funct3[1:0])
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = |req_addr[1:0];
            default: misaligned = |req_addr[2:0];
        endcase
    end

    assign illegal = req_write ? req_funct3[2] : (req_funct3 == 3'b111);
    assign req_err = misaligned | illegal;

    lsu_lane_align u_align (
        .funct3     (r_funct3),
        .offset     (r_offset),
        .rdata      (read_data),
        .wdata      (r_wdata),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err)                 state_nxt = RESP;
                    else if (!req_write)         state_nxt = LOAD;
                    else if (req_funct3 == F3_D) state_nxt = WRITE;
                    else                         state_nxt = RMW_RD;
                end
            end
            LOAD: begin
                mem_read  = 1'b1;
                state_nxt = RESP;
            end
            RMW_RD: begin
                mem_read  = 1'b1;
                state_nxt = WRITE;
            end
            WRITE: begin
                mem_write = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            r_funct3   <= '0;
            r_offset   <= '0;
            r_wdata    <= '0;
            endereco   <= '0;
            write_data <= '0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        r_funct3 <= req_funct3;
                        r_offset <= req_addr[2:0];
                        r_wdata  <= req_wdata;
                        // errors never touch the memory port, so its registers keep their values
                        if (req_err) begin
                            resp_rdata <= '0;
                            resp_error <= 1'b1;
                        end else begin
                            endereco <= {req_addr[ADDR_W-1:3], 3'b000};
                            if (req_write && req_funct3 == F3_D)
                                write_data <= req_wdata;
                        end
                    end
                end
                LOAD: begin
                    resp_rdata <= load_data;
                    resp_error <= 1'b0;
                end
                RMW_RD: write_data <= merge_data;
                WRITE: begin
                    resp_rdata <= '0;
                    resp_error <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-side initiator for the 64-bit `data_memory`. It accepts one RV64 load or store request at a time from the execute stage and issues the matching `mem_read`/`mem_write` sequence on the memory's doubleword port. It performs byte-lane extraction with sign or zero extension for loads, and read-modify-write merging for sub-word stores. It sits between the pipeline's MEM stage control and `data_memory`, and reports data or an error back with a one-cycle response pulse.

## Interface
- `ADDR_W`, 8: byte address width; matches `endereco`.
- `XLEN`, 64: data width.

- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: block idle; a request is accepted when `req_valid & req_ready`.
- `req_write` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RISC-V funct3.
  - Loads: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU.
  - Stores: 000 SB, 001 SH, 010 SW, 011 SD.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in XLEN: store data; low bytes are used for sub-word stores.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out XLEN: extended load data; 0 for stores and errors.
- `resp_error` out 1: misaligned address or illegal funct3; qualified by `resp_valid`.
- `mem_read` out 1: to `data_memory`.
- `mem_write` out 1: to `data_memory`.
- `endereco` out ADDR_W: doubleword-aligned address `{addr[7:3],3'b000}`.
- `write_data` out XLEN: full doubleword written.
- `read_data` in XLEN: from `data_memory`.

## Operation
- `data_memory` contract:
  - `read_data` is combinational from `endereco` while `mem_read` is high.
  - A write commits on the rising `clk` edge while `mem_write` is high.
- Byte lanes are little-endian: byte k = `[8k+7:8k]`, with k = `addr[2:0]`.
- On accept, register `write`, `funct3`, `addr` and `wdata`.
- FSM states: IDLE, LOAD, RMW_RD, WRITE, RESP.
- IDLE: `req_ready`=1. On accept, the next state is:
  - RESP with error, if misaligned (H: `addr[0]`≠0; W: `addr[1:0]`≠0; D: `addr[2:0]`≠0), or if funct3 is 111 for a load, or ≥100 for a store.
  - LOAD, for a legal load.
  - WRITE, for SD.
  - RMW_RD, for SB/SH/SW.
- LOAD: `mem_read`=1. Capture the extracted and extended lane into `resp_rdata`, then go to RESP.
- RMW_RD: `mem_read`=1. Register the merge of `read_data` with the store bytes into `write_data` (only the selected lanes are replaced), then go to WRITE.
- WRITE: `mem_write`=1 for exactly one cycle. For SD, `write_data`=`wdata`. Then go to RESP.
- RESP: `resp_valid`=1 for one cycle, then go to IDLE.
  - There is no response back-pressure.
  - `resp_rdata`/`resp_error` hold until the next response.
- Errors never assert `mem_read` or `mem_write`.
- `mem_read` and `mem_write` are never high in the same cycle.

## Timing
- Accept edge = cycle 0.
- Response latency (`resp_valid` cycle):
  - Load: 2.
  - SD: 2.
  - SB/SH/SW: 3.
  - Error: 1.
- Back-to-back throughput: a new request can be accepted in the cycle after RESP (IDLE).
- `mem_read`/`mem_write` are Moore outputs decoded from state.
- `endereco` and `write_data` are registered and stable for the whole access state.
- Reset values:
  - State: IDLE.
  - `resp_valid`, `resp_error`, `mem_read`, `mem_write`: 0.
  - `resp_rdata`, `endereco`, `write_data`: 0.
- A request presented while `reset` is high is ignored.
- Reset mid-operation (any state): the next cycle is IDLE with all outputs at reset values. No `resp_valid` is issued for the aborted request. A store aborted before WRITE leaves memory unchanged.

## Structure
- Package `lsu_pkg`:
  - funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_D`, `F3_BU`, `F3_HU`, `F3_WU`).
  - State enum `lsu_state_t`.
  - `XLEN`.
- Sub-module `lsu_lane_align` (combinational):
  - Load extract plus sign/zero extension.
  - Store merge with lane mask.
- The FSM and registers stay in `load_store_unit`.

## Test plan
All scenarios preload `mem[8]` = `0x8877665544332211` unless noted.

1. LD addr 8 -> cycle 1 `mem_read`=1, `endereco`=8; cycle 2 `resp_valid`=1, `resp_rdata`=`0x8877665544332211`, `resp_error`=0.
2. LB addr 15 -> `resp_rdata`=`0xFFFFFFFFFFFFFF88`. LBU addr 15 -> `0x0000000000000088`.
3. LW addr 12 -> `0xFFFFFFFF88776655`. LWU addr 12 -> `0x0000000088776655`. LH addr 10 -> `0x0000000000004433`.
4. SH addr 10, wdata `0x1234ABCD` -> one `mem_read` cycle, then one `mem_write` cycle with `write_data`=`0x88776655ABCD2211`; `resp_valid` at cycle 3. A following LD addr 8 returns `0x88776655ABCD2211`.
5. LW addr 6 -> `resp_error`=1 at cycle 1, `resp_rdata`=0, no `mem_read`/`mem_write` pulse. A store with funct3 100 also returns an error.
6. SD addr 24, wdata 11, with `reset` high in the WRITE cycle -> no `resp_valid`; `req_ready`=1 after reset. A new LD addr 24 completes normally.
